// File: rtl/uart_rx_fifo_wr_if.sv
// Write port between the UART receiver and the downstream FIFO.
interface uart_rx_fifo_wr_if;
   logic       wr;
   logic [7:0] din;
   logic       full;

   modport master (output wr, output din, input full);
   modport slave  (input wr, input din, output full);
endinterface

// File: rtl/uart_rx_fifo_wr.sv
// 8N1 UART receiver that pushes each good byte into a downstream FIFO.
// Bad stop bits and bytes dropped on a full FIFO are kept as sticky flags.
module uart_rx_fifo_wr #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   input  logic               clr_err,
   uart_rx_fifo_wr_if.master  fifo,
   output logic               busy,
   output logic               frame_err,
   output logic               overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HLAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      bitcnt;
   logic [7:0]      shreg;
   logic            sync1, rxs;
   logic            wr_q;
   logic [7:0]      din_q;

   assign fifo.wr  = wr_q;
   assign fifo.din = din_q;
   assign busy     = (state != IDLE);

   // Two-flop synchronizer on the raw line; resets to the idle (high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   // Frame FSM: mid-bit sampling, byte assembly, FIFO write and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         wr_q      <= 1'b0;
         din_q     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         // Clear first so a set in the same cycle (later assignment) wins.
         if (clr_err) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state  <= START;
                  cnt    <= '0;
                  bitcnt <= '0;
               end
            end
            START: begin
               if (cnt == HLAST) begin
                  cnt   <= '0;
                  // A start bit that is gone at mid-bit was a glitch.
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt    <= '0;
                  shreg  <= {rxs, shreg[7:1]};
                  bitcnt <= bitcnt + 4'd1;
                  if (bitcnt == 4'd7) state <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     if (!fifo.full) begin
                        wr_q  <= 1'b1;
                        din_q <= shreg;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               // Hold off until the line idles so a long low is not a new start.
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr at the default bit period.
module tb_uart_rx_fifo_wr;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst, rx, clr_err;
   logic busy, frame_err, overrun;

   uart_rx_fifo_wr_if fif ();

   uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .clr_err   (clr_err),
      .fifo      (fif.master),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int wr_cyc = 0;
   int dbl = 0;
   logic prev_wr = 1'b0;
   logic [7:0] dq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every write strobe away from the active edge.
   always @(negedge clk) begin
      if (fif.wr === 1'b1) begin
         wr_cnt++;
         wr_cyc = cyc;
         dq.push_back(fif.din);
         if (prev_wr) dbl++;
      end
      prev_wr = (fif.wr === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bitp(input logic b);
      rx = b;
      idle(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb);
      bitp(1'b0);
      for (int i = 0; i < 8; i++) bitp(d[i]);
      bitp(stopb);
      rx = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
   endtask

   int t0;
   int lat;

   initial begin
      rst = 1'b1; rx = 1'b1; clr_err = 1'b0; fif.full = 1'b0;
      idle(3);
      chk("rst_wr", fif.wr, 0);
      chk("rst_din", fif.din, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_ov", overrun, 0);
      rst = 1'b0;
      idle(4);

      // Single good frame and its latency.
      t0 = cyc;
      send_frame(8'hA5, 1'b1);
      idle(4);
      lat = wr_cyc - t0;
      chk("a5_cnt", wr_cnt, 1);
      chk("a5_din", fif.din, 8'hA5);
      chk("a5_lat_in_154_156", (lat >= 154 && lat <= 156), 1);
      chk("a5_fe", frame_err, 0);
      chk("a5_ov", overrun, 0);
      chk("a5_busy", busy, 0);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(4);
      chk("b2b_cnt", wr_cnt, 3);
      chk("b2b_d0", (dq.size() > 1) ? dq[1] : 8'hXX, 8'h00);
      chk("b2b_d1", (dq.size() > 2) ? dq[2] : 8'hXX, 8'hFF);
      chk("b2b_din", fif.din, 8'hFF);

      // Bad stop bit: sticky frame error, then clear and recover.
      send_frame(8'h3C, 1'b0);
      idle(20);
      chk("fe_cnt", wr_cnt, 3);
      chk("fe_set", frame_err, 1);
      chk("fe_busy", busy, 0);
      idle(50);
      chk("fe_sticky", frame_err, 1);
      pulse_clr();
      chk("fe_clr", frame_err, 0);
      send_frame(8'h12, 1'b1);
      idle(4);
      chk("12_cnt", wr_cnt, 4);
      chk("12_din", fif.din, 8'h12);

      // Full FIFO at the stop sample: drop and flag.
      fif.full = 1'b1;
      send_frame(8'h55, 1'b1);
      fif.full = 1'b0;
      idle(4);
      chk("ov_cnt", wr_cnt, 4);
      chk("ov_set", overrun, 1);
      chk("ov_din", fif.din, 8'h12);
      chk("ov_fe", frame_err, 0);
      pulse_clr();
      chk("ov_clr", overrun, 0);

      // Short low glitch is rejected at mid start bit.
      rx = 1'b0;
      idle(4);
      chk("gl_busy_hi", busy, 1);
      rx = 1'b1;
      idle(2 * CPB);
      chk("gl_busy", busy, 0);
      chk("gl_cnt", wr_cnt, 4);
      chk("gl_fe", frame_err, 0);
      chk("gl_ov", overrun, 0);

      // Reset in the middle of data bit 4 of 0xF0.
      bitp(1'b0);
      for (int i = 0; i < 4; i++) bitp(1'(8'hF0 >> i));
      rx = 1'b1;
      idle(CPB / 2);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mr_wr", fif.wr, 0);
      chk("mr_din", fif.din, 8'h00);
      chk("mr_busy", busy, 0);
      chk("mr_fe", frame_err, 0);
      chk("mr_ov", overrun, 0);
      idle(3);
      rst = 1'b0;
      idle(2 * CPB);
      chk("mr_cnt", wr_cnt, 4);
      send_frame(8'h81, 1'b1);
      idle(4);
      chk("81_cnt", wr_cnt, 5);
      chk("81_din", fif.din, 8'h81);
      chk("81_q", (dq.size() > 4) ? dq[4] : 8'hXX, 8'h81);
      chk("no_dbl_wr", dbl, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/uart_rx_fifo_wr.md
UART_RX_FIFO_WR -- requirements
Module: uart_rx_fifo_wr

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 4..1023.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 SHALL have port full  input  1  downstream FIFO full flag.
REQ-006 SHALL have port clr_err  input  1  single-cycle pulse clearing sticky error flags.
REQ-007 SHALL have port wr  output  1  one-cycle write strobe to downstream FIFO.
REQ-008 SHALL have port din  output  8  received byte, valid while wr=1.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port frame_err  output  1  sticky flag, stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky flag, byte dropped because full=1.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; only the synchronized value (rxs) is used internally.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on rxs=0 go to START with bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division) sample rxs; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag).
REQ-016 DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, shift in LSB first; after 8th sample go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> valid byte, go to IDLE; 0 -> set frame_err, no write, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rxs=1, then go to IDLE.
REQ-019 Valid byte with full=0 at the stop-sample cycle: SHALL assert wr for exactly one cycle on the next clock with din=byte.
REQ-020 Valid byte with full=1 at the stop-sample cycle: SHALL NOT assert wr, SHALL set overrun, din unchanged.
REQ-021 din SHALL hold the last written byte between writes.
REQ-022 wr SHALL never be asserted for more than one consecutive cycle per frame.
REQ-023 Cycle counter SHALL be $clog2(CLKS_PER_BIT)+1 bits, bit counter 4 bits; no wrap-around during a frame.
REQ-024 Latency: wr rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for sync phase) after rx falls; 155 cycles at default.
REQ-025 clr_err clears frame_err and overrun on the next edge; set condition in the same cycle SHALL win.
REQ-026 New start bit SHALL be accepted in the cycle after returning to IDLE (back-to-back frames).

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, wr=0, din=0x00, busy=0, frame_err=0, overrun=0, counters 0, synchronizer flops 1.
REQ-028 rst asserted mid-frame SHALL discard the partial byte with no wr pulse; reception resumes on the first start bit after rst=0.

Verification
REQ-029 Frame 0xA5, valid stop, full=0, default parameter -> one wr pulse, din=0xA5, 155±1 cycles after start edge, flags 0.
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two single-cycle wr pulses, din=0x00 then 0xFF.
REQ-031 Frame 0x3C with stop bit low -> no wr, frame_err=1 until clr_err pulse, then 0; next valid frame 0x12 written.
REQ-032 Frame 0x55 with full=1 at stop sample -> no wr, overrun=1, din retains previous value.
REQ-033 rx low for 4 cycles then high -> returns to IDLE, busy low, no wr, no flags.
REQ-034 rst pulsed during data bit 4 of frame 0xF0 -> wr=0 and all outputs at reset values immediately; following frame 0x81 written correctly.
